// File: rtl/ota_bias_cal_ctrl_if.sv
// Bundle between the test sequencer and the adaptive-OTA bias calibration controller.
//   master modport (sequencer side): drives en, start, cmp_ok; observes the rest.
//   slave  modport (controller side): consumes en, start, cmp_ok; drives
//     step_en, code, ib, busy, done, fail.
// NBIT must match the NBIT of the controller it is connected to.
interface ota_bias_cal_ctrl_if #(
    parameter int unsigned NBIT = 6
);
    logic            en;       // block enable, low aborts a run
    logic            start;    // one-cycle calibration request
    logic            cmp_ok;   // window comparator, 1 = output settled in tolerance
    logic            step_en;  // 1 = apply input step to the OTA
    logic [NBIT-1:0] code;     // bias DAC code
    real             ib;       // bias current in A, piecewise constant
    logic            busy;
    logic            done;     // sticky pass flag
    logic            fail;     // sticky fail flag

    modport master (
        output en, start, cmp_ok,
        input  step_en, code, ib, busy, done, fail
    );

    modport slave (
        input  en, start, cmp_ok,
        output step_en, code, ib, busy, done, fail
    );
endinterface

// File: rtl/ota_bias_cal_ctrl.sv
// Bias calibration controller for the adaptive OTA.
// Runs a successive-approximation search for the smallest bias code whose step response
// settles within tolerance, adds MARGIN, then verifies the final code once.
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   ota_bias_cal_ctrl_if.slave: en/start/cmp_ok in; step_en/code/ib/busy/done/fail out
// ib is a real-valued, piecewise-constant current derived combinationally from the code
// register, so it moves on the same edge as the code (and immediately on reset).
module ota_bias_cal_ctrl #(
    parameter int unsigned NBIT         = 6,
    parameter int unsigned SETTLE_CYC   = 16,   // 1..255
    parameter int unsigned MARGIN       = 2,
    parameter int unsigned CODE_DEFAULT = 32,
    parameter real         IB_MIN       = 2e-6,
    parameter real         IB_LSB       = 0.5e-6
) (
    input logic                clk,
    input logic                rstn,
    ota_bias_cal_ctrl_if.slave bus
);

    localparam int unsigned PW = (NBIT > 1) ? $clog2(NBIT) : 1;

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StPre    = 4'd1;
    localparam logic [3:0] StStep   = 4'd2;
    localparam logic [3:0] StSample = 4'd3;
    localparam logic [3:0] StUpdate = 4'd4;
    localparam logic [3:0] StVPre   = 4'd5;
    localparam logic [3:0] StVStep  = 4'd6;
    localparam logic [3:0] StVSamp  = 4'd7;
    localparam logic [3:0] StDone   = 4'd8;
    localparam logic [3:0] StFail   = 4'd9;

    localparam logic [NBIT-1:0] CodeMax = '1;
    localparam logic [NBIT-1:0] CodeDef = NBIT'(CODE_DEFAULT);
    localparam logic [PW-1:0]   PtrMsb  = PW'(NBIT - 1);
    localparam logic [7:0]      CntLast = 8'(SETTLE_CYC - 1);

    logic [3:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NBIT-1:0] code_q, code_d;
    logic [NBIT-1:0] acc_q, acc_d;
    logic [PW-1:0]   bitptr_q, bitptr_d;
    logic            cmp_q, cmp_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;

    logic            phase_last;
    logic [NBIT-1:0] acc_new;
    logic [PW-1:0]   bitptr_dec;
    logic [NBIT+1:0] sum;
    logic [NBIT-1:0] final_code;

    assign phase_last = (cnt_q == CntLast);
    // A failed trial means the trial code is too weak, so its bit is kept.
    assign acc_new    = cmp_q ? acc_q : code_q;
    assign bitptr_dec = bitptr_q - PW'(1);
    // Widened by two bits so acc+1+MARGIN cannot wrap before saturation.
    assign sum        = {2'b00, acc_new} + (NBIT + 2)'(MARGIN + 1);
    assign final_code = (sum > {2'b00, CodeMax}) ? CodeMax : sum[NBIT-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        acc_d    = acc_q;
        bitptr_d = bitptr_q;
        cmp_d    = cmp_q;
        done_d   = done_q;
        fail_d   = fail_q;

        if (state_q != StIdle && !bus.en) begin
            // Abort: back to the power-on picture, no partial result kept.
            state_d  = StIdle;
            cnt_d    = '0;
            code_d   = CodeDef;
            acc_d    = '0;
            bitptr_d = PtrMsb;
            done_d   = 1'b0;
            fail_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start && bus.en) begin
                        state_d  = StPre;
                        cnt_d    = '0;
                        acc_d    = '0;
                        bitptr_d = PtrMsb;
                        code_d   = NBIT'(1) << PtrMsb;
                        done_d   = 1'b0;
                        fail_d   = 1'b0;
                    end
                end
                StPre, StVPre: begin
                    if (phase_last) begin
                        cnt_d   = '0;
                        state_d = (state_q == StPre) ? StStep : StVStep;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StStep, StVStep: begin
                    if (phase_last) begin
                        cnt_d   = '0;
                        state_d = (state_q == StStep) ? StSample : StVSamp;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StSample: begin
                    cmp_d   = bus.cmp_ok;
                    state_d = StUpdate;
                end
                StUpdate: begin
                    acc_d = acc_new;
                    if (bitptr_q != '0) begin
                        bitptr_d = bitptr_dec;
                        code_d   = acc_new | (NBIT'(1) << bitptr_dec);
                        state_d  = StPre;
                    end else if (acc_new == CodeMax) begin
                        // Even the strongest code failed; verifying it is pointless.
                        code_d  = CodeMax;
                        state_d = StFail;
                    end else begin
                        code_d  = final_code;
                        state_d = StVPre;
                    end
                end
                StVSamp: begin
                    state_d = bus.cmp_ok ? StDone : StFail;
                end
                StDone: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                StFail: begin
                    fail_d  = 1'b1;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            code_q   <= CodeDef;
            acc_q    <= '0;
            bitptr_q <= PtrMsb;
            cmp_q    <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            acc_q    <= acc_d;
            bitptr_q <= bitptr_d;
            cmp_q    <= cmp_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    // Outputs decode straight from the state register.
    assign bus.step_en = (state_q == StStep)  || (state_q == StSample) ||
                         (state_q == StVStep) || (state_q == StVSamp);
    assign bus.busy    = (state_q != StIdle) && (state_q != StDone) && (state_q != StFail);
    assign bus.code    = code_q;
    assign bus.done    = done_q;
    assign bus.fail    = fail_q;
    assign bus.ib      = IB_MIN + real'(code_q) * IB_LSB;

endmodule
